// File: rtl/rv_ctrl_pkg.sv
// Shared types, encodings and decode helpers for the multicycle RV32I controller.
package rv_ctrl_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned ALU_CODE_W = 4;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
        ALUWB, JAL, JALR, JALRPC, BRANCH, LUI, AUIPC, TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RD1 = 2'b10, SRCA_ZERO = 2'b11;
    localparam logic [1:0] SRCB_RD2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURESULT = 2'b10;
    localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100;
    localparam logic [1:0] ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10;

    localparam logic [ALU_CODE_W-1:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
        ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR = 4'd8, ALU_AND = 4'd9;

    // Unknown opcodes and reserved funct3 encodings of known opcodes.
    function automatic logic is_illegal(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            OP_LOAD:   return f3 inside {3'b011, 3'b110, 3'b111};
            OP_STORE:  return f3 >= 3'b011;
            OP_BRANCH: return f3 inside {3'b010, 3'b011};
            OP_JALR:   return f3 != 3'b000;
            OP_R, OP_I, OP_JAL, OP_LUI, OP_AUIPC: return 1'b0;
            default:   return 1'b1;
        endcase
    endfunction

    function automatic logic [2:0] imm_src(input logic [6:0] op);
        case (op)
            OP_STORE:        return IMM_S;
            OP_BRANCH:       return IMM_B;
            OP_JAL:          return IMM_J;
            OP_LUI, OP_AUIPC: return IMM_U;
            default:         return IMM_I;
        endcase
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic zero,
                                          input logic neg, input logic ult);
        case (f3)
            3'b000:  return zero;
            3'b001:  return !zero;
            3'b100:  return neg;
            3'b101:  return !neg;
            3'b110:  return ult;
            3'b111:  return !ult;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Controller <-> datapath signal bundle; master is the control unit.
interface multicycle_control_unit_if #(
    parameter int unsigned ALU_CTRL_W = 4
);
    logic [31:0]           Instr;
    logic                  Zero, Negflag, Unsigned_less_than, mem_ready;
    logic                  mem_req, AdrSrc, IRWrite, PCUpdate;
    logic [1:0]            ALUSrcA, ALUSrcB, ResultSrc;
    logic [2:0]            ImmSrc;
    logic                  RegWrite, MemWrite;
    logic [2:0]            Loadtype;
    logic [1:0]            Storetype;
    logic                  Jalr;
    logic [ALU_CTRL_W-1:0] ALUControl;
    logic                  instr_done, trap;

    modport master (
        input  Instr, Zero, Negflag, Unsigned_less_than, mem_ready,
        output mem_req, AdrSrc, IRWrite, PCUpdate, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc,
               RegWrite, MemWrite, Loadtype, Storetype, Jalr, ALUControl, instr_done, trap
    );

    modport slave (
        output Instr, Zero, Negflag, Unsigned_less_than, mem_ready,
        input  mem_req, AdrSrc, IRWrite, PCUpdate, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc,
               RegWrite, MemWrite, Loadtype, Storetype, Jalr, ALUControl, instr_done, trap
    );
endinterface

// File: rtl/alu_decoder.sv
// Maps ALUOp plus funct3/funct7[30]/op[5] onto an ALU operation code.
module alu_decoder
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W = 4
) (
    input  logic [2:0]            funct3,
    input  logic                  funct7b5,
    input  logic                  opb5,
    input  logic [1:0]            alu_op,
    output logic [ALU_CTRL_W-1:0] alu_control
);
    logic [ALU_CODE_W-1:0] code;

    // funct7[30] selects SUB only for R-type; shifts use it for both forms.
    always_comb begin
        code = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: code = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000: code = (opb5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001: code = ALU_SLL;
                    3'b010: code = ALU_SLT;
                    3'b011: code = ALU_SLTU;
                    3'b100: code = ALU_XOR;
                    3'b101: code = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110: code = ALU_OR;
                    3'b111: code = ALU_AND;
                    default: code = ALU_ADD;
                endcase
            end
            default: code = ALU_ADD;
        endcase
    end

    assign alu_control = ALU_CTRL_W'(code);

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore FSM sequencing each RV32I instruction through the shared-memory multicycle datapath.
module multicycle_control_unit
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned MEM_HANDSHAKE = 1,
    parameter int unsigned TRAP_EN       = 1,
    parameter int unsigned ALU_CTRL_W    = 4
) (
    input logic                        clk,
    input logic                        rst_n,
    multicycle_control_unit_if.master  bus
);
    state_t     state, next_state;
    logic       trap_q, rdy, illegal;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       mem_req_c, adr_src_c, ir_write_c, pc_update_c;
    logic       reg_write_c, mem_write_c, done_c, jalr_c;
    logic [1:0] src_a_c, src_b_c, result_src_c, alu_op_c;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic       unused_instr_bits;

    assign opcode  = bus.Instr[6:0];
    assign funct3  = bus.Instr[14:12];
    assign illegal = is_illegal(opcode, funct3);
    assign rdy     = (MEM_HANDSHAKE != 0) ? bus.mem_ready : 1'b1;
    assign unused_instr_bits = ^{bus.Instr[31], bus.Instr[29:15], bus.Instr[11:7]};

    alu_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_decoder (
        .funct3      (funct3),
        .funct7b5    (bus.Instr[30]),
        .opb5        (bus.Instr[5]),
        .alu_op      (alu_op_c),
        .alu_control (alu_control)
    );

    // trap is sticky: only reset leaves the TRAP state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= FETCH;
            trap_q <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state == TRAP) trap_q <= 1'b1;
        end
    end

    always_comb begin
        next_state   = state;
        mem_req_c    = 1'b0;
        adr_src_c    = 1'b0;
        ir_write_c   = 1'b0;
        pc_update_c  = 1'b0;
        reg_write_c  = 1'b0;
        mem_write_c  = 1'b0;
        done_c       = 1'b0;
        jalr_c       = 1'b0;
        src_a_c      = SRCA_PC;
        src_b_c      = SRCB_RD2;
        result_src_c = RES_ALUOUT;
        alu_op_c     = ALUOP_ADD;
        case (state)
            FETCH: begin
                mem_req_c    = 1'b1;
                src_b_c      = SRCB_FOUR;
                result_src_c = RES_ALURESULT;
                ir_write_c   = rdy;
                pc_update_c  = rdy;
                if (rdy) next_state = DECODE;
            end
            DECODE: begin
                src_a_c = SRCA_OLDPC;
                src_b_c = SRCB_IMM;
                if (illegal) begin
                    if (TRAP_EN != 0) begin
                        next_state = TRAP;
                    end else begin
                        next_state = FETCH;
                        done_c     = 1'b1;
                    end
                end else begin
                    case (opcode)
                        OP_LOAD, OP_STORE: next_state = MEMADR;
                        OP_R:      next_state = EXECR;
                        OP_I:      next_state = EXECI;
                        OP_JAL:    next_state = JAL;
                        OP_JALR:   next_state = JALR;
                        OP_BRANCH: next_state = BRANCH;
                        OP_LUI:    next_state = LUI;
                        OP_AUIPC:  next_state = AUIPC;
                        default:   next_state = FETCH;
                    endcase
                end
            end
            MEMADR: begin
                src_a_c    = SRCA_RD1;
                src_b_c    = SRCB_IMM;
                next_state = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req_c = 1'b1;
                adr_src_c = 1'b1;
                if (rdy) next_state = MEMWB;
            end
            MEMWB: begin
                result_src_c = RES_DATA;
                reg_write_c  = 1'b1;
                done_c       = 1'b1;
                next_state   = FETCH;
            end
            MEMWRITE: begin
                mem_req_c   = 1'b1;
                adr_src_c   = 1'b1;
                mem_write_c = 1'b1;
                done_c      = rdy;
                if (rdy) next_state = FETCH;
            end
            EXECR: begin
                src_a_c    = SRCA_RD1;
                alu_op_c   = ALUOP_FUNCT;
                next_state = ALUWB;
            end
            EXECI: begin
                src_a_c    = SRCA_RD1;
                src_b_c    = SRCB_IMM;
                alu_op_c   = ALUOP_FUNCT;
                next_state = ALUWB;
            end
            LUI: begin
                src_a_c    = SRCA_ZERO;
                src_b_c    = SRCB_IMM;
                next_state = ALUWB;
            end
            AUIPC: begin
                src_a_c    = SRCA_OLDPC;
                src_b_c    = SRCB_IMM;
                next_state = ALUWB;
            end
            ALUWB: begin
                reg_write_c = 1'b1;
                done_c      = 1'b1;
                next_state  = FETCH;
            end
            // PC takes the target latched in DECODE; link value OldPC+4 goes to ALUOut.
            JAL: begin
                src_a_c     = SRCA_OLDPC;
                src_b_c     = SRCB_FOUR;
                pc_update_c = 1'b1;
                next_state  = ALUWB;
            end
            JALR: begin
                src_a_c    = SRCA_RD1;
                src_b_c    = SRCB_IMM;
                next_state = JALRPC;
            end
            JALRPC: begin
                src_a_c     = SRCA_OLDPC;
                src_b_c     = SRCB_FOUR;
                jalr_c      = 1'b1;
                pc_update_c = 1'b1;
                next_state  = ALUWB;
            end
            BRANCH: begin
                src_a_c     = SRCA_RD1;
                alu_op_c    = ALUOP_SUB;
                done_c      = 1'b1;
                pc_update_c = branch_taken(funct3, bus.Zero, bus.Negflag, bus.Unsigned_less_than);
                next_state  = FETCH;
            end
            TRAP:    next_state = TRAP;
            default: next_state = FETCH;
        endcase
    end

    // Enables are held off for the whole time rst_n is asserted.
    assign bus.mem_req    = rst_n & mem_req_c;
    assign bus.IRWrite    = rst_n & ir_write_c;
    assign bus.PCUpdate   = rst_n & pc_update_c;
    assign bus.RegWrite   = rst_n & reg_write_c;
    assign bus.MemWrite   = rst_n & mem_write_c;
    assign bus.instr_done = rst_n & done_c;
    assign bus.AdrSrc     = adr_src_c;
    assign bus.Jalr       = jalr_c;
    assign bus.ALUSrcA    = src_a_c;
    assign bus.ALUSrcB    = src_b_c;
    assign bus.ResultSrc  = result_src_c;
    assign bus.ALUControl = alu_control;
    assign bus.ImmSrc     = imm_src(opcode);
    assign bus.Loadtype   = funct3;
    assign bus.Storetype  = funct3[1:0];
    assign bus.trap       = trap_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench: per-cycle vector table on the handshake/trap build, hand sequences on the no-handshake/no-trap build.
module tb_multicycle_control_unit;
    import rv_ctrl_pkg::*;

    localparam logic [31:0] I_ADD   = 32'h002081B3, I_SUB  = 32'h402081B3, I_SRAI = 32'h4020D193;
    localparam logic [31:0] I_ADDI  = 32'h40008193, I_BEQ  = 32'h00208463, I_BGEU = 32'h0020F463;
    localparam logic [31:0] I_BLT   = 32'h0020C463, I_BNE  = 32'h00209463, I_LW   = 32'h0000A183;
    localparam logic [31:0] I_SW    = 32'h0020A023, I_JAL  = 32'h008000EF, I_JALR = 32'h000280E7;
    localparam logic [31:0] I_LUI   = 32'h123451B7, I_AUIPC = 32'h12345197, I_ILL = 32'h0000007F;
    localparam logic [31:0] I_BR010 = 32'h0020A463, I_LBU  = 32'h0000C183;

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  f;      // {Zero, Negflag, Unsigned_less_than, mem_ready}
        state_t      st;
        logic [7:0]  ctl;    // {mem_req, AdrSrc, IRWrite, PCUpdate, RegWrite, MemWrite, instr_done, Jalr}
        logic [1:0]  sa, sb, rs;
        logic [3:0]  alu;
        logic        trp;
    } vec_t;

    logic clk, rst_n;
    int   total, passed;
    vec_t tbl[$];

    multicycle_control_unit_if #(.ALU_CTRL_W(4)) bus0 ();
    multicycle_control_unit_if #(.ALU_CTRL_W(4)) bus1 ();

    assign bus1.Instr              = bus0.Instr;
    assign bus1.Zero               = bus0.Zero;
    assign bus1.Negflag            = bus0.Negflag;
    assign bus1.Unsigned_less_than = bus0.Unsigned_less_than;
    assign bus1.mem_ready          = bus0.mem_ready;

    multicycle_control_unit #(.MEM_HANDSHAKE(1), .TRAP_EN(1), .ALU_CTRL_W(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    multicycle_control_unit #(.MEM_HANDSHAKE(0), .TRAP_EN(0), .ALU_CTRL_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    function automatic logic [7:0] ctl0();
        return {bus0.mem_req, bus0.AdrSrc, bus0.IRWrite, bus0.PCUpdate,
                bus0.RegWrite, bus0.MemWrite, bus0.instr_done, bus0.Jalr};
    endfunction

    function automatic logic [7:0] ctl1();
        return {bus1.mem_req, bus1.AdrSrc, bus1.IRWrite, bus1.PCUpdate,
                bus1.RegWrite, bus1.MemWrite, bus1.instr_done, bus1.Jalr};
    endfunction

    task automatic drive(input logic [31:0] i, input logic [3:0] f);
        bus0.Instr              = i;
        bus0.Zero               = f[3];
        bus0.Negflag            = f[2];
        bus0.Unsigned_less_than = f[1];
        bus0.mem_ready          = f[0];
    endtask

    task automatic av(input logic [31:0] i, input logic [3:0] f, input state_t st, input logic [7:0] ctl,
                      input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] rs,
                      input logic [3:0] alu, input logic t);
        vec_t v;
        v.instr = i; v.f = f; v.st = st; v.ctl = ctl;
        v.sa = sa; v.sb = sb; v.rs = rs; v.alu = alu; v.trp = t;
        tbl.push_back(v);
    endtask

    // FETCH with memory ready, then DECODE (branch/JAL target add).
    task automatic fd(input logic [31:0] i, input logic [3:0] f);
        av(i, f | 4'b0001, FETCH,  8'hB0, 2'd0, 2'd2, 2'd2, 4'd0, 1'b0);
        av(i, f & 4'b1110, DECODE, 8'h00, 2'd1, 2'd1, 2'd0, 4'd0, 1'b0);
    endtask

    // Runs one instruction on the no-handshake build with mem_ready low; checks latency and writeback.
    task automatic lat1(input string name, input logic [31:0] i, input logic [3:0] f,
                        input int exp_cyc, input logic exp_rw, input logic [1:0] exp_rs);
        int cyc = 0;
        logic seen = 1'b0;
        logic rw = 1'b0;
        logic [1:0] rs = 2'b11;
        while (!seen && cyc < 16) begin
            drive(i, f & 4'b1110);
            #1;
            cyc++;
            if (bus1.instr_done) begin
                seen = 1'b1;
                rw   = bus1.RegWrite;
                rs   = bus1.ResultSrc;
            end
            @(negedge clk);
        end
        chk({name, "_latency"}, 64'(cyc), 64'(exp_cyc));
        chk({name, "_wb"}, 64'({rw, rs}), 64'({exp_rw, exp_rs}));
    endtask

    initial begin
        total = 0;
        passed = 0;
        rst_n = 1'b0;
        drive(I_ADD, 4'b0000);

        av(I_ADD, 4'b0000, FETCH, 8'h80, 2'd0, 2'd2, 2'd2, 4'd0, 1'b0);
        fd(I_ADD, 4'b0000);
        av(I_ADD, 4'b0000, EXECR, 8'h00, 2'd2, 2'd0, 2'd0, 4'd0, 1'b0);
        av(I_ADD, 4'b0000, ALUWB, 8'h0A, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0);
        fd(I_SUB, 4'b0000);
        av(I_SUB, 4'b0000, EXECR, 8'h00, 2'd2, 2'd0, 2'd0, 4'd1, 1'b0);
        av(I_SUB, 4'b0000, ALUWB, 8'h0A, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0);
        fd(I_SRAI, 4'b0000);
        av(I_SRAI, 4'b0000, EXECI, 8'h00, 2'd2, 2'd1, 2'd0, 4'd7, 1'b0);
        av(I_SRAI, 4'b0000, ALUWB, 8'h0A, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0);
        fd(I_ADDI, 4'b0000);
        av(I_ADDI, 4'b0000, EXECI, 8'h00, 2'd2, 2'd1, 2'd0, 4'd0, 1'b0);
        av(I_ADDI, 4'b0000, ALUWB, 8'h0A, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0);
        fd(I_BEQ, 4'b1000);
        av(I_BEQ, 4'b1000, BRANCH, 8'h12, 2'd2, 2'd0, 2'd0, 4'd1, 1'b0);
        fd(I_BGEU, 4'b0010);
        av(I_BGEU, 4'b0010, BRANCH, 8'h02, 2'd2, 2'd0, 2'd0, 4'd1, 1'b0);
        fd(I_BLT, 4'b0100);
        av(I_BLT, 4'b0100, BRANCH, 8'h12, 2'd2, 2'd0, 2'd0, 4'd1, 1'b0);
        fd(I_BNE, 4'b1000);
        av(I_BNE, 4'b1000, BRANCH, 8'h02, 2'd2, 2'd0, 2'd0, 4'd1, 1'b0);
        fd(I_LW, 4'b0000);
        av(I_LW, 4'b0000, MEMADR, 8'h00, 2'd2, 2'd1, 2'd0, 4'd0, 1'b0);
        for (int k = 0; k < 3; k++) av(I_LW, 4'b0000, MEMREAD, 8'hC0, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0);
        av(I_LW, 4'b0001, MEMREAD, 8'hC0, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0);
        av(I_LW, 4'b0000, MEMWB, 8'h0A, 2'd0, 2'd0, 2'd1, 4'd0, 1'b0);
        fd(I_SW, 4'b0000);
        av(I_SW, 4'b0000, MEMADR, 8'h00, 2'd2, 2'd1, 2'd0, 4'd0, 1'b0);
        for (int k = 0; k < 2; k++) av(I_SW, 4'b0000, MEMWRITE, 8'hC4, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0);
        av(I_SW, 4'b0001, MEMWRITE, 8'hC6, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0);
        av(I_JAL, 4'b0000, FETCH, 8'h80, 2'd0, 2'd2, 2'd2, 4'd0, 1'b0);
        fd(I_JAL, 4'b0000);
        av(I_JAL, 4'b0000, JAL, 8'h10, 2'd1, 2'd2, 2'd0, 4'd0, 1'b0);
        av(I_JAL, 4'b0000, ALUWB, 8'h0A, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0);
        fd(I_JALR, 4'b0000);
        av(I_JALR, 4'b0000, JALR, 8'h00, 2'd2, 2'd1, 2'd0, 4'd0, 1'b0);
        av(I_JALR, 4'b0000, JALRPC, 8'h11, 2'd1, 2'd2, 2'd0, 4'd0, 1'b0);
        av(I_JALR, 4'b0000, ALUWB, 8'h0A, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0);
        fd(I_LUI, 4'b0000);
        av(I_LUI, 4'b0000, LUI, 8'h00, 2'd3, 2'd1, 2'd0, 4'd0, 1'b0);
        av(I_LUI, 4'b0000, ALUWB, 8'h0A, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0);
        fd(I_AUIPC, 4'b0000);
        av(I_AUIPC, 4'b0000, AUIPC, 8'h00, 2'd1, 2'd1, 2'd0, 4'd0, 1'b0);
        av(I_AUIPC, 4'b0000, ALUWB, 8'h0A, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0);
        fd(I_ILL, 4'b0000);
        for (int k = 0; k < 3; k++) av(I_ILL, 4'b0001, TRAP, 8'h00, 2'd0, 2'd0, 2'd0, 4'd0, 1'b1);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k].instr, tbl[k].f);
            #1;
            chk($sformatf("vec%0d", k),
                64'({dut0.state, ctl0(), bus0.ALUSrcA, bus0.ALUSrcB, bus0.ResultSrc, bus0.ALUControl, bus0.trap}),
                64'({tbl[k].st, tbl[k].ctl, tbl[k].sa, tbl[k].sb, tbl[k].rs, tbl[k].alu, tbl[k].trp}));
            @(negedge clk);
        end

        // Reset out of TRAP with memory ready: FETCH, enables off, trap cleared.
        rst_n = 1'b0;
        drive(I_ADD, 4'b0001);
        #1;
        chk("rst_state0", 64'(dut0.state), 64'(FETCH));
        chk("rst_en0", 64'(ctl0()), 64'h0);
        chk("rst_trap0", 64'(bus0.trap), 64'h0);
        chk("rst_en1", 64'(ctl1()), 64'h0);

        // No-handshake build: FETCH ignores mem_ready; reset abandons add in EXECR.
        @(negedge clk);
        rst_n = 1'b1;
        drive(I_ADD, 4'b0000);
        #1;
        chk("nh_fetch", 64'({dut1.state, ctl1()}), 64'({FETCH, 8'hB0}));
        @(negedge clk); #1;
        chk("nh_decode", 64'(dut1.state), 64'(DECODE));
        @(negedge clk); #1;
        chk("nh_execr", 64'({dut1.state, ctl1(), bus1.ALUControl}), 64'({EXECR, 8'h00, 4'd0}));
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_state", 64'({dut1.state, ctl1()}), 64'({FETCH, 8'h00}));
        @(posedge clk); #1;
        chk("midrst_hold", 64'({dut1.state, ctl1(), bus1.trap}), 64'({FETCH, 8'h00, 1'b0}));
        @(negedge clk);
        rst_n = 1'b1;

        lat1("add", I_ADD, 4'b0000, 4, 1'b1, 2'b00);
        lat1("beq", I_BEQ, 4'b1000, 3, 1'b0, 2'b00);
        lat1("sw", I_SW, 4'b0000, 4, 1'b0, 2'b00);
        lat1("jal", I_JAL, 4'b0000, 4, 1'b1, 2'b00);
        lat1("jalr", I_JALR, 4'b0000, 5, 1'b1, 2'b00);
        lat1("lw", I_LW, 4'b0000, 5, 1'b1, 2'b01);
        lat1("lui", I_LUI, 4'b0000, 4, 1'b1, 2'b00);
        lat1("ill_nop", I_ILL, 4'b0000, 2, 1'b0, 2'b00);

        // Reserved branch funct3: trap build traps, no-trap build retires it as a NOP.
        drive(I_BR010, 4'b0001);
        #1;
        chk("br010_fetch", 64'({dut0.state, dut1.state}), 64'({FETCH, FETCH}));
        @(negedge clk); #1;
        chk("br010_dec0", 64'({dut0.state, ctl0(), bus0.trap}), 64'({DECODE, 8'h00, 1'b0}));
        chk("br010_dec1", 64'({dut1.state, ctl1()}), 64'({DECODE, 8'h02}));
        @(negedge clk); #1;
        chk("br010_nop1", 64'({dut1.state, bus1.trap}), 64'({FETCH, 1'b0}));
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("trap_hold%0d", k), 64'({dut0.state, ctl0(), bus0.trap}), 64'({TRAP, 8'h00, 1'b1}));
            @(negedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("trap_clear", 64'({dut0.state, bus0.trap}), 64'({FETCH, 1'b0}));

        // Instr-field decodes, checked while held in reset.
        drive(I_LW, 4'b0000);   #1; chk("lw_fields", 64'({bus0.ImmSrc, bus0.Loadtype}), 64'({3'b000, 3'b010}));
        drive(I_LBU, 4'b0000);  #1; chk("lbu_ltype", 64'(bus0.Loadtype), 64'(3'b100));
        drive(I_SW, 4'b0000);   #1; chk("sw_fields", 64'({bus0.ImmSrc, bus0.Storetype}), 64'({3'b001, 2'b10}));
        drive(I_BEQ, 4'b0000);  #1; chk("beq_imm", 64'(bus0.ImmSrc), 64'(3'b010));
        drive(I_JAL, 4'b0000);  #1; chk("jal_imm", 64'(bus0.ImmSrc), 64'(3'b011));
        drive(I_LUI, 4'b0000);  #1; chk("lui_imm", 64'(bus0.ImmSrc), 64'(3'b100));
        drive(I_AUIPC, 4'b0000); #1; chk("auipc_imm", 64'(bus0.ImmSrc), 64'(3'b100));
        drive(I_JALR, 4'b0000); #1; chk("jalr_imm", 64'(bus0.ImmSrc), 64'(3'b000));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
